acs_unit: RTL and testbench
===========================

ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 Parameters: none; 4-state trellis (K=3, rate 1/2), 7-bit path metrics, 2-bit state addresses are fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_sig  input  1  input valid strobe; inputs sampled when 1.
REQ-005 self_state  input  2  trellis state this cell computes, {s1,s0}, s1 = newest encoder input bit.
REQ-006 data_recv  input  2  received hard-decision symbol {c0,c1}.
REQ-007 addr_in_1  input  2  predecessor state of candidate path 1.
REQ-008 addr_in_2  input  2  predecessor state of candidate path 2.
REQ-009 PMin1  input  7  path metric of predecessor addr_in_1, unsigned.
REQ-010 PMin2  input  7  path metric of predecessor addr_in_2, unsigned.
REQ-011 PMout  output  7  selected (surviving) path metric, registered.
REQ-012 addr_out  output  2  predecessor state of the survivor, registered.
REQ-013 data_rdy  output  1  outputs valid pulse, registered.
REQ-014 dec_out  output  1  decoded bit of the transition into self_state, registered.

Function
REQ-015 Encoder model: transition predecessor p={p1,p0} with input u goes to state {u,p1}; expected symbol c0 = u^p1^p0 (g=7 octal), c1 = u^p0 (g=5 octal).
REQ-016 For each candidate i, u = self_state[1]; expected symbol from u and addr_in_i per REQ-015.
REQ-017 Branch metric BMi = Hamming distance between data_recv and expected symbol, range 0..2.
REQ-018 Candidate valid only if addr_in_i[1] == self_state[0]; invalid candidate metric forced to 127.
REQ-019 Valid candidate metric = PMini + BMi, saturating at 127 (no wrap-around).
REQ-020 Select: candidate with strictly smaller metric wins; tie selects candidate 1.
REQ-021 On clk edge with input_sig=1 and rst=0: PMout <= winning metric, addr_out <= winning addr_in, dec_out <= self_state[1], data_rdy <= 1.
REQ-022 On clk edge with input_sig=0 and rst=0: PMout, addr_out, dec_out hold; data_rdy <= 0.
REQ-023 Latency: exactly 1 clock from sampled input to outputs; data_rdy high for one cycle per sampled input, continuous when input_sig held high (one result per cycle).
REQ-024 Both candidates invalid: PMout=127, addr_out=addr_in_1 (tie rule).
REQ-025 Purely combinational ACS path between input sampling and output register; no other internal state.

Reset
REQ-026 rst=1 at a clk edge: PMout=0, addr_out=00, dec_out=0, data_rdy=0, overriding input_sig.
REQ-027 rst asserted mid-stream discards the sample of that cycle; first valid result after rst deasserts appears one clock after the first input_sig=1 edge.

Verification
REQ-028 rst=1 one edge -> PMout=0, addr_out=00, data_rdy=0, dec_out=0.
REQ-029 self_state=00, addr_in_1=00, addr_in_2=01, data_recv=00, PMin1=10, PMin2=5, input_sig=1 -> next cycle PMout=7, addr_out=01, dec_out=0, data_rdy=1.
REQ-030 Same as REQ-029 with PMin1=7 -> tie at 7: PMout=7, addr_out=00.
REQ-031 self_state=00, addr 00/01, data_recv=11, PMin1=127, PMin2=126 -> PMout=126 (candidate 1 saturates at 127), addr_out=01.
REQ-032 self_state=00, addr_in_1=00, addr_in_2=11 (invalid), data_recv=00, PMin1=120, PMin2=0 -> PMout=120, addr_out=00; self_state=10, addr 00/01, data_recv=00, PMin1=3, PMin2=4 -> PMout=4, addr_out=01, dec_out=1.
REQ-033 input_sig=0 after a valid result -> data_rdy=0 next cycle, PMout/addr_out/dec_out unchanged regardless of input changes.

Source files
------------

// File: rtl/acs_unit.sv
// Add-compare-select cell for a 4-state, rate-1/2 (7,5) Viterbi decoder.
// One trellis state per instance; survivor metric and predecessor registered.
module acs_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_sig,
  input  logic [1:0] self_state,
  input  logic [1:0] data_recv,
  input  logic [1:0] addr_in_1,
  input  logic [1:0] addr_in_2,
  input  logic [6:0] PMin1,
  input  logic [6:0] PMin2,
  output logic [6:0] PMout,
  output logic [1:0] addr_out,
  output logic       data_rdy,
  output logic       dec_out
);

  localparam int unsigned PM_W = 7;
  localparam logic [PM_W-1:0] PM_MAX = '1;

  // Hamming distance between the received symbol {c0,c1} and the encoder output for (u, p).
  function automatic logic [1:0] branch_metric(input logic u, input logic [1:0] p,
                                               input logic [1:0] r);
    logic c0;
    logic c1;
    c0 = u ^ p[1] ^ p[0];
    c1 = u ^ p[0];
    return 2'({1'b0, r[1] ^ c0} + {1'b0, r[0] ^ c1});
  endfunction

  // Saturating candidate metric; a predecessor that cannot reach self_state gets the maximum.
  function automatic logic [PM_W-1:0] cand_metric(input logic [1:0] s, input logic [1:0] p,
                                                  input logic [1:0] r, input logic [PM_W-1:0] pm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + (PM_W + 1)'(branch_metric(s[1], p, r));
    if (p[1] != s[0]) begin
      return PM_MAX;
    end else if (sum > {1'b0, PM_MAX}) begin
      return PM_MAX;
    end else begin
      return sum[PM_W-1:0];
    end
  endfunction

  logic [PM_W-1:0] metric_1_c;
  logic [PM_W-1:0] metric_2_c;
  logic            sel_2_c;

  always_comb begin
    metric_1_c = cand_metric(self_state, addr_in_1, data_recv, PMin1);
    metric_2_c = cand_metric(self_state, addr_in_2, data_recv, PMin2);
    // Ties resolve toward candidate 1.
    sel_2_c    = (metric_2_c < metric_1_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PMout    <= '0;
      addr_out <= '0;
      dec_out  <= 1'b0;
      data_rdy <= 1'b0;
    end else if (input_sig) begin
      PMout    <= sel_2_c ? metric_2_c : metric_1_c;
      addr_out <= sel_2_c ? addr_in_2 : addr_in_1;
      dec_out  <= self_state[1];
      data_rdy <= 1'b1;
    end else begin
      data_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_unit.sv
// Directed plus randomized checks of acs_unit against a trellis-level reference model.
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_sig;
  logic [1:0] self_state;
  logic [1:0] data_recv;
  logic [1:0] addr_in_1;
  logic [1:0] addr_in_2;
  logic [6:0] PMin1;
  logic [6:0] PMin2;
  logic [6:0] PMout;
  logic [1:0] addr_out;
  logic       data_rdy;
  logic       dec_out;

  int tests = 0;
  int fails = 0;

  // Reference state: what the outputs should hold after the last edge.
  int m_pm = 0;
  int m_addr = 0;
  int m_dec = 0;
  int m_rdy = 0;

  acs_unit dut (
    .clk       (clk),
    .rst       (rst),
    .input_sig (input_sig),
    .self_state(self_state),
    .data_recv (data_recv),
    .addr_in_1 (addr_in_1),
    .addr_in_2 (addr_in_2),
    .PMin1     (PMin1),
    .PMin2     (PMin2),
    .PMout     (PMout),
    .addr_out  (addr_out),
    .data_rdy  (data_rdy),
    .dec_out   (dec_out)
  );

  always #5 clk = ~clk;

  // Cost of reaching state s from predecessor p with metric pm, given received symbol r.
  function automatic int path_cost(int s, int p, int r, int pm);
    int u, nxt, c0, c1, r0, r1, bm;
    u   = (s >> 1) & 1;
    nxt = u * 2 + ((p >> 1) & 1);
    if (nxt != s) return 127;
    c0 = (u + ((p >> 1) & 1) + (p & 1)) % 2;
    c1 = (u + (p & 1)) % 2;
    r0 = (r >> 1) & 1;
    r1 = r & 1;
    bm = ((c0 != r0) ? 1 : 0) + ((c1 != r1) ? 1 : 0);
    return (pm + bm > 127) ? 127 : pm + bm;
  endfunction

  task automatic model_edge();
    int k1, k2;
    if (rst) begin
      m_pm = 0; m_addr = 0; m_dec = 0; m_rdy = 0;
    end else if (input_sig) begin
      k1 = path_cost(int'(self_state), int'(addr_in_1), int'(data_recv), int'(PMin1));
      k2 = path_cost(int'(self_state), int'(addr_in_2), int'(data_recv), int'(PMin2));
      m_pm   = (k2 < k1) ? k2 : k1;
      m_addr = (k2 < k1) ? int'(addr_in_2) : int'(addr_in_1);
      m_dec  = int'(self_state[1]);
      m_rdy  = 1;
    end else begin
      m_rdy = 0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PMout"},    8'(PMout),    8'(m_pm));
    check({tag, ".addr_out"}, 8'(addr_out), 8'(m_addr));
    check({tag, ".dec_out"},  8'(dec_out),  8'(m_dec));
    check({tag, ".data_rdy"}, 8'(data_rdy), 8'(m_rdy));
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [1:0] d,
                       input logic [1:0] a1, input logic [1:0] a2,
                       input logic [6:0] p1, input logic [6:0] p2);
    rst = r; input_sig = v; self_state = s; data_recv = d;
    addr_in_1 = a1; addr_in_2 = a2; PMin1 = p1; PMin2 = p2;
  endtask

  // Advance one edge, update the model with the inputs that edge sampled, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    drive(1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 7'd50, 7'd60);
    step("reset");
    check("reset.PMout.const", 8'(PMout), 8'd0);
    check("reset.addr.const",  8'(addr_out), 8'd0);

    drive(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'd10, 7'd5);
    step("cand2_wins");
    check("cand2_wins.PMout.const", 8'(PMout), 8'd7);
    check("cand2_wins.addr.const",  8'(addr_out), 8'd1);

    drive(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 7'd7, 7'd5);
    step("tie");
    check("tie.addr.const", 8'(addr_out), 8'd0);

    drive(1'b0, 1'b1, 2'b00, 2'b11, 2'b00, 2'b01, 7'd127, 7'd126);
    step("saturate");
    check("saturate.PMout.const", 8'(PMout), 8'd126);

    drive(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 7'd120, 7'd0);
    step("invalid2");
    check("invalid2.PMout.const", 8'(PMout), 8'd120);

    drive(1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01, 7'd3, 7'd4);
    step("u1");
    check("u1.PMout.const", 8'(PMout), 8'd4);
    check("u1.dec.const",   8'(dec_out), 8'd1);

    drive(1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b01, 7'd20, 7'd30);
    step("both_invalid");
    check("both_invalid.PMout.const", 8'(PMout), 8'd127);

    drive(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b11, 7'd1, 7'd2);
    step("hold");
    check("hold.rdy.const", 8'(data_rdy), 8'd0);
    drive(1'b0, 1'b0, 2'b10, 2'b11, 2'b11, 2'b10, 7'd0, 7'd0);
    step("hold2");

    drive(1'b0, 1'b1, 2'b11, 2'b01, 2'b10, 2'b11, 7'd40, 7'd41);
    step("restart");
    drive(1'b1, 1'b1, 2'b11, 2'b01, 2'b10, 2'b11, 7'd9, 7'd9);
    step("mid_reset");
    drive(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b11, 7'd9, 7'd9);
    step("post_reset_idle");
    drive(1'b0, 1'b1, 2'b11, 2'b00, 2'b10, 2'b11, 7'd9, 7'd12);
    step("post_reset_first");

    for (int i = 0; i < 400; i++) begin
      logic [6:0] p1, p2;
      p1 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom);
      p2 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom);
      drive(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), p1, p2);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
